// File: rtl/sram_axi_bridge_pkg.sv
// Shared definitions for the SRAM-like to AXI3 bridge.
//
// Contents:
//   state_t         bridge FSM state encoding
//   KSEG_* params   kseg0/kseg1 detection and translation constants
//   AXI_* params    fixed AXI3 attribute values driven by the top-level wrapper
package sram_axi_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        D_AR = 3'd1,
        D_R  = 3'd2,
        D_AW = 3'd3,
        D_B  = 3'd4,
        I_AR = 3'd5,
        I_R  = 3'd6,
        DONE = 3'd7
    } state_t;

    // Top two address bits that identify kseg0/kseg1, and how many top bits
    // get cleared to reach the physical address (0x8000_0000 -> 0x0000_0000).
    localparam logic [1:0]  KSEG_SEL       = 2'b10;
    localparam int          KSEG_CLR_BITS  = 3;
    localparam logic [31:0] KSEG_MASK      = 32'h1FFF_FFFF;

    // Single-beat, full-word, INCR transfers only.
    localparam logic [3:0]  AXI_ID    = 4'd0;
    localparam logic [3:0]  AXI_LEN   = 4'd0;
    localparam logic [2:0]  AXI_SIZE  = 3'd2;
    localparam logic [1:0]  AXI_BURST = 2'd1;
    localparam logic [3:0]  AXI_CACHE = 4'd0;
    localparam logic [2:0]  AXI_PROT  = 3'd0;

endpackage

// File: rtl/sram_axi_bridge_addr_map.sv
// Combinational kseg0/kseg1 virtual-to-physical translation.
//
// Ports:
//   addr         virtual address from the core
//   mapped_addr  address issued on the AXI bus
//
// With KSEG_MAP=1 any address whose top two bits are 2'b10 has its top three
// bits cleared; every other address, and every address when KSEG_MAP=0,
// passes through unchanged.
module sram_axi_bridge_addr_map
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int KSEG_MAP = 1
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [ADDR_W-1:0] mapped_addr
);

    always_comb begin
        mapped_addr = addr;
        if ((KSEG_MAP != 0) && (addr[ADDR_W-1 -: 2] == KSEG_SEL)) begin
            mapped_addr[ADDR_W-1 -: KSEG_CLR_BITS] = '0;
        end
    end

endmodule

// File: rtl/sram_axi_bridge.sv
// Bridge from the core's instruction/data SRAM-like ports to a single AXI3
// master port. One AXI transaction is outstanding at a time; a data access
// is always serviced before the instruction fetch of the same cycle, and the
// pipeline is frozen through stallreq until both have completed.
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   inst_sram_*                   fetch request / held fetch data
//   data_sram_*                   load/store request / held load data
//   stallreq                      freeze request to the pipeline controller
//   ar*/r*                        AXI read address and read data channels
//   aw*/w*/b*                     AXI write address, data and response channels
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int KSEG_MAP = 1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_sram_en,
    input  logic [ADDR_W-1:0] inst_sram_addr,
    output logic [31:0]       inst_sram_rdata,

    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_wen,
    input  logic [ADDR_W-1:0] data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,

    output logic              stallreq,

    output logic [ADDR_W-1:0] araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic              rvalid,
    output logic              rready,

    output logic [ADDR_W-1:0] awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic              bvalid,
    output logic              bready
);

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] inst_addr_q;
    logic [ADDR_W-1:0] data_addr_q;
    logic [3:0]        data_wen_q;
    logic [31:0]       data_wdata_q;
    logic [31:0]       inst_rdata_q;
    logic [31:0]       data_rdata_q;
    logic              inst_pend;
    logic              data_pend;
    logic              aw_done;
    logic              w_done;

    logic              any_req;
    logic              is_store;
    logic [ADDR_W-1:0] rd_addr_raw;

    assign any_req  = inst_sram_en | data_sram_en;
    assign is_store = data_sram_en & (data_sram_wen != 4'b0000);

    // The read channel serves the data load first; once data_pend clears the
    // same channel naturally switches over to the fetch address.
    assign rd_addr_raw = data_pend ? data_addr_q : inst_addr_q;

    sram_axi_bridge_addr_map #(
        .ADDR_W   (ADDR_W),
        .KSEG_MAP (KSEG_MAP)
    ) u_rd_map (
        .addr        (rd_addr_raw),
        .mapped_addr (araddr)
    );

    sram_axi_bridge_addr_map #(
        .ADDR_W   (ADDR_W),
        .KSEG_MAP (KSEG_MAP)
    ) u_wr_map (
        .addr        (data_addr_q),
        .mapped_addr (awaddr)
    );

    assign wdata           = data_wdata_q;
    assign wstrb           = data_wen_q;
    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        stallreq   = 1'b1;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;

        case (state)
            IDLE: begin
                // Qualified by rst so the pipeline is released the moment
                // reset is applied, even if the core still holds a request.
                stallreq = any_req & rst;
                if (any_req) begin
                    if (is_store) begin
                        state_next = D_AW;
                    end else if (data_sram_en) begin
                        state_next = D_AR;
                    end else begin
                        state_next = I_AR;
                    end
                end
            end
            D_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = D_R;
                end
            end
            D_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = inst_pend ? I_AR : DONE;
                end
            end
            D_AW: begin
                // Address and data channels complete independently; each
                // valid drops as soon as its own handshake has happened.
                awvalid = ~aw_done;
                wvalid  = ~w_done;
                if ((aw_done | awready) && (w_done | wready)) begin
                    state_next = D_B;
                end
            end
            D_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    state_next = inst_pend ? I_AR : DONE;
                end
            end
            I_AR: begin
                arvalid = 1'b1;
                if (arready) begin
                    state_next = I_R;
                end
            end
            I_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                stallreq   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_addr_q  <= '0;
            data_addr_q  <= '0;
            data_wen_q   <= '0;
            data_wdata_q <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_pend    <= 1'b0;
            data_pend    <= 1'b0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        inst_addr_q  <= inst_sram_addr;
                        data_addr_q  <= data_sram_addr;
                        data_wen_q   <= data_sram_wen;
                        data_wdata_q <= data_sram_wdata;
                        inst_pend    <= inst_sram_en;
                        data_pend    <= data_sram_en;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                    end
                end
                D_R: begin
                    if (rvalid) begin
                        data_rdata_q <= rdata;
                        data_pend    <= 1'b0;
                    end
                end
                D_AW: begin
                    if (awvalid && awready) begin
                        aw_done <= 1'b1;
                    end
                    if (wvalid && wready) begin
                        w_done <= 1'b1;
                    end
                end
                D_B: begin
                    if (bvalid) begin
                        data_pend <= 1'b0;
                    end
                end
                I_R: begin
                    if (rvalid) begin
                        inst_rdata_q <= rdata;
                        inst_pend    <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/sram_axi_bridge.md
Name: sram_axi_bridge

Overview:
Sits directly downstream of the CPU core. It consumes the core's inst/data SRAM-like request ports and issues one AXI3 transaction at a time on a 32-bit master port. It holds the returned read data for the core and raises stallreq to freeze the pipeline until every request of the current cycle has completed. Data requests take priority over instruction fetch.

Parameters:
ADDR_W, 32, address width on both sides.
KSEG_MAP, 1, when 1: addresses with addr[31:30]==2'b10 (kseg0/kseg1) have bits [31:29] cleared before issue; when 0: addresses pass through unchanged.

Ports:
clk  in  1  clock; all state on rising edge
rst  in  1  reset, asynchronous, active-low
inst_sram_en  in  1  fetch request
inst_sram_addr  in  ADDR_W  fetch address, word aligned
inst_sram_rdata  out  32  fetched word, held until next fetch completes
data_sram_en  in  1  data request
data_sram_wen  in  4  byte enables; nonzero = store, zero = load
data_sram_addr  in  ADDR_W  data address
data_sram_wdata  in  32  store data
data_sram_rdata  out  32  load word, held until next load completes
stallreq  out  1  freeze pipeline, routed into CTRL
araddr  out  ADDR_W  read address
arvalid  out  1  read address valid
arready  in  1  read address accept
rdata  in  32  read data
rvalid  in  1  read data valid
rready  out  1  read data accept
awaddr  out  ADDR_W  write address
awvalid  out  1  write address valid
awready  in  1  write address accept
wdata  out  32  write data
wstrb  out  4  = latched data_sram_wen
wvalid  out  1  write data valid
wready  in  1  write data accept
bvalid  in  1  write response valid
bready  out  1  write response accept
AXI id/len(0)/size(2)/burst(1)/cache/prot are tied off in the top wrapper, not here.

Behaviour:
- Reset (rst=0, async): state=IDLE. All valid/ready outputs 0. Both rdata holds = 0. Pending flags cleared. stallreq=0. An in-flight AXI transaction is abandoned; the interconnect shares the same reset.
- States: IDLE, D_AR, D_R, D_AW, D_B, I_AR, I_R, DONE.
- IDLE: stallreq = inst_sram_en | data_sram_en (combinational). On an edge with any request: latch addr/wen/wdata, set inst_pend/data_pend. Go to D_AW if a store is pending, else D_AR if a load is pending, else I_AR.
- D_AR/I_AR: arvalid=1, araddr = latched address after mapping. On arready go to D_R/I_R.
- D_R/I_R: rready=1. On rvalid: capture rdata into data_sram_rdata or inst_sram_rdata and clear that pending flag. Next state is I_AR if inst_pend is still set, else DONE.
- D_AW: awvalid and wvalid are asserted together. Each is dropped independently after its handshake (aw_done/w_done flags). When both are done go to D_B.
- D_B: bready=1. On bvalid clear data_pend and go to I_AR or DONE.
- DONE: stallreq=0 for exactly one cycle so the core advances; rdata holds stay valid. Next state is IDLE.
- stallreq=1 in every state other than IDLE (request-dependent) and DONE.
- Zero-wait slave read: request at cycle 0 gives arvalid in cycle 1, rvalid in cycle 2, DONE in cycle 3. Store: aw/w in cycle 1, b in cycle 2, DONE in cycle 3.
- Inputs change only while stallreq=0, so latched copies are authoritative during a transaction.
- Never more than one outstanding AXI transaction. Valid outputs stay stable until their handshake completes (AXI rule).
- A read response and a write response are never both expected at once. An rvalid or bvalid that is not expected is ignored, with ready held 0.

Decomposition:
- Shared package/defines header: state encodings, KSEG mapping mask, tied-off AXI constants.
- One sub-module is natural: addr_map (combinational KSEG translation), instantiated for both the read and write address paths.
- FSM and handshake logic stay in sram_axi_bridge.

Test Plan:
1. Fetch only, addr 0xBFC00000, arready=1, rvalid one cycle later with rdata=0x24010001 -> araddr=0x1FC00000; stallreq 1 for cycles 0-2 and 0 in cycle 3; inst_sram_rdata=0x24010001.
2. Same-cycle load 0x80001000 plus fetch 0xBFC00004 -> AR order is 0x00001000 then 0x1FC00004; DONE reached only after both; both rdata holds are correct.
3. Store wen=4'b0011, wdata=0x0000BEEF, awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle, awvalid held 4 cycles; wstrb=0011; bready then DONE.
4. arready held low 5 cycles -> arvalid and araddr stable throughout; stallreq stays 1.
5. rst driven low while in D_R -> all valids 0 and stallreq 0 immediately (asynchronously); after release, state=IDLE and a new fetch proceeds normally.
6. KSEG_MAP=0, fetch 0xBFC00000 -> araddr=0xBFC00000.
